// File: rtl/gate_result_checker.sv
// gate_result_checker
//   Scores an upstream gate block (AND, OR, NOT, BUF) against the expected
//   bitwise results for a run of num_vec vectors.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse, begins a run (ignored while busy)
//   num_vec           vectors in the run, latched on start
//   in_valid          A, B, Out1..Out4 carry a vector this cycle
//   A, B              operands fed to the gate block
//   Out1..Out4        gate block AND, OR, NOT, BUF results
//   busy, done        run in progress / run finished (results stable)
//   pass_cnt          vectors with all four outputs correct
//   fail_cnt          vectors with at least one wrong output
//   err               sticky, set on the first failing vector of the run
//   first_fail_idx    0-based index of the first failing vector
//   fail_mask         mismatch bits of the latest failure {BUF,NOT,OR,AND}
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting vectors, scoring one cycle after acceptance
// DONE  | all num_vec results counted; holds until start
module gate_result_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Out1,
    input  logic [WIDTH-1:0] Out2,
    input  logic [WIDTH-1:0] Out3,
    input  logic [WIDTH-1:0] Out4,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [3:0]       fail_mask
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] acc_cnt;
    logic             p_valid;
    logic [WIDTH-1:0] p_a, p_b, p_o1, p_o2, p_o3, p_o4;
    logic [3:0]       mism;
    logic             accept;
    logic [CNT_W-1:0] res_idx;

    // Compare stage works on the registered copy of the accepted vector.
    always_comb begin
        mism    = 4'd0;
        mism[0] = (p_o1 != (p_a & p_b));
        mism[1] = (p_o2 != (p_a | p_b));
        mism[2] = (p_o3 != ~p_a);
        mism[3] = (p_o4 != p_a);
    end

    // Once num_vec vectors are in, further in_valid is dropped.
    assign accept  = (state == RUN) && in_valid && (acc_cnt != num_lat);
    // Results are counted in order, so the scored vector's index is the
    // number of results already counted.
    assign res_idx = pass_cnt + fail_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            err            <= 1'b0;
            first_fail_idx <= '0;
            fail_mask      <= 4'd0;
            num_lat        <= '0;
            acc_cnt        <= '0;
            p_valid        <= 1'b0;
            p_a            <= '0;
            p_b            <= '0;
            p_o1           <= '0;
            p_o2           <= '0;
            p_o3           <= '0;
            p_o4           <= '0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_a  <= A;
                p_b  <= B;
                p_o1 <= Out1;
                p_o2 <= Out2;
                p_o3 <= Out3;
                p_o4 <= Out4;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        err            <= 1'b0;
                        first_fail_idx <= '0;
                        fail_mask      <= 4'd0;
                        acc_cnt        <= '0;
                        num_lat        <= num_vec;
                        if (num_vec == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (accept)
                        acc_cnt <= acc_cnt + 1'b1;
                    if (p_valid) begin
                        if (mism == 4'd0) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end else begin
                            fail_cnt  <= fail_cnt + 1'b1;
                            fail_mask <= mism;
                            err       <= 1'b1;
                            if (!err)
                                first_fail_idx <= res_idx;
                        end
                        // No accept is possible once acc_cnt hits num_lat,
                        // so a result seen then is the last one.
                        if (acc_cnt == num_lat) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_result_checker.sv
module tb_gate_result_checker;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [7:0] num_vec;
    logic [3:0] A, B, Out1, Out2, Out3, Out4;
    logic       busy, done, err;
    logic [7:0] pass_cnt, fail_cnt, first_fail_idx;
    logic [3:0] fail_mask;

    int checks = 0;
    int errors = 0;

    // Reference model: list of accepted vectors' mismatch masks, how many of
    // those have been scored, and the phase (0 idle, 1 run, 2 done).
    int masks[$];
    int counted, inflight, mnum, phase;

    gate_result_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
        .in_valid(in_valid), .A(A), .B(B),
        .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .err(err), .first_fail_idx(first_fail_idx), .fail_mask(fail_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int vec_mask(input logic [3:0] a, b, o1, o2, o3, o4);
        logic [3:0] e_and, e_or, e_not;
        int m;
        e_and = a & b;
        e_or  = a | b;
        e_not = ~a;
        m = 0;
        if (o1 != e_and) m += 1;
        if (o2 != e_or)  m += 2;
        if (o3 != e_not) m += 4;
        if (o4 != a)     m += 8;
        return m;
    endfunction

    // Drive a vector; bad selects which outputs get corrupted by xor value x.
    task automatic drv(input logic [3:0] a, b, input logic [3:0] bad, input logic [3:0] x);
        logic [3:0] na;
        na       = ~a;
        in_valid = 1'b1;
        A        = a;
        B        = b;
        Out1     = (a & b) ^ (bad[0] ? x : 4'd0);
        Out2     = (a | b) ^ (bad[1] ? x : 4'd0);
        Out3     = na      ^ (bad[2] ? x : 4'd0);
        Out4     = a       ^ (bad[3] ? x : 4'd0);
    endtask

    task automatic go(input int n);
        start   = 1'b1;
        num_vec = 8'(n);
    endtask

    // Advance one clock: update the model with the current inputs, let the
    // DUT see the edge, then compare every output.
    task automatic step(input string tag);
        int p, f, e, ff, fm;
        if (rst) begin
            phase = 0; masks.delete(); counted = 0; inflight = 0;
        end else if (phase != 1) begin
            if (start) begin
                masks.delete(); counted = 0; inflight = 0;
                mnum  = int'(num_vec);
                phase = (mnum == 0) ? 2 : 1;
            end
        end else begin
            counted += inflight;
            inflight = 0;
            if (in_valid && masks.size() < mnum) begin
                masks.push_back(vec_mask(A, B, Out1, Out2, Out3, Out4));
                inflight = 1;
            end
            if (counted == mnum) phase = 2;
        end
        @(posedge clk);
        #1;
        p = 0; f = 0; e = 0; ff = 0; fm = 0;
        for (int i = 0; i < counted; i++) begin
            if (masks[i] == 0) p++;
            else begin
                if (e == 0) ff = i;
                e = 1; f++; fm = masks[i];
            end
        end
        chk({tag, "_busy"}, 32'(busy), 32'(phase == 1));
        chk({tag, "_done"}, 32'(done), 32'(phase == 2));
        chk({tag, "_pass"}, 32'(pass_cnt), p);
        chk({tag, "_fail"}, 32'(fail_cnt), f);
        chk({tag, "_err"},  32'(err), e);
        chk({tag, "_ffi"},  32'(first_fail_idx), ff);
        chk({tag, "_mask"}, 32'(fail_mask), fm);
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] ta [6];
        logic [3:0] tb [6];
        ta = '{4'd3, 4'd1, 4'd5, 4'd12, 4'd15, 4'd11};
        tb = '{4'd2, 4'd0, 4'd6, 4'd9,  4'd10, 4'd3};
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_vec = 8'd0;
        A = 4'd0; B = 4'd0; Out1 = 4'd0; Out2 = 4'd0; Out3 = 4'd0; Out4 = 4'd0;
        counted = 0; inflight = 0; mnum = 0; phase = 0;
        step("rst0");
        step("rst1");
        rst = 1'b0;
        step("idle");

        // six correct vectors
        go(6); step("s6");
        for (int i = 0; i < 6; i++) begin
            drv(ta[i], tb[i], 4'd0, 4'd0);
            step("v6");
        end
        step("v6_last");
        chk("r033_pass_const", 32'(pass_cnt), 6);
        chk("r033_done_const", 32'(done), 1);

        // AND wrong on vector 0
        go(2); step("s2");
        drv(4'd5, 4'd6, 4'b0001, 4'd1); step("v2a");
        drv(4'd9, 4'd7, 4'd0, 4'd0);    step("v2b");
        step("v2c");
        chk("r034_mask_const", 32'(fail_mask), 1);
        chk("r034_fail_const", 32'(fail_cnt), 1);

        // NOT wrong on vector 1, BUF wrong on vector 2
        go(3); step("s3");
        drv(4'd2, 4'd8, 4'd0, 4'd0);    step("v3a");
        drv(4'd6, 4'd3, 4'b0100, 4'd2); step("v3b");
        drv(4'd10, 4'd5, 4'b1000, 4'd4); step("v3c");
        step("v3d");
        chk("r035_ffi_const", 32'(first_fail_idx), 1);
        chk("r035_mask_const", 32'(fail_mask), 8);

        // empty run, then gapped run
        go(0); step("s0");
        step("s0_hold");
        go(4); step("s4");
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drv(4'(i), 4'(i * 3), 4'd0, 4'd0);
            step("gap");
        end
        step("gap_end");

        // start pulses during run, extra valid after the count is reached
        go(3); step("s3b");
        drv(4'd1, 4'd2, 4'd0, 4'd0); go(7); step("sr_a");
        drv(4'd3, 4'd4, 4'b0010, 4'd8); go(1); step("sr_b");
        drv(4'd5, 4'd6, 4'd0, 4'd0); step("sr_c");
        drv(4'd7, 4'd8, 4'b1111, 4'd15); step("sr_extra");
        drv(4'd7, 4'd8, 4'b1111, 4'd15); step("done_extra");

        // reset mid-run with a vector in flight
        go(4); step("s4r");
        drv(4'd1, 4'd1, 4'b0001, 4'd3); step("rv0");
        drv(4'd2, 4'd2, 4'd0, 4'd0);    step("rv1");
        rst = 1'b1; drv(4'd3, 4'd3, 4'd0, 4'd0); step("rrst");
        rst = 1'b0;
        drv(4'd4, 4'd4, 4'b0001, 4'd1); step("r_ign0");
        drv(4'd5, 4'd5, 4'd0, 4'd0);    step("r_ign1");

        // randomized runs
        for (int r = 0; r < 30; r++) begin
            go($urandom_range(0, 8)); step("rs");
            for (int c = 0; c < 60 && phase == 1; c++) begin
                if ($urandom_range(0, 9) < 7) begin
                    if ($urandom_range(0, 2) == 0)
                        drv(4'($urandom), 4'($urandom), 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
                    else
                        drv(4'($urandom), 4'($urandom), 4'd0, 4'd0);
                end
                if ($urandom_range(0, 9) == 0) go($urandom_range(0, 8));
                if ($urandom_range(0, 49) == 0) rst = 1'b1;
                step("rnd");
                rst = 1'b0;
            end
            drv(4'($urandom), 4'($urandom), 4'd0, 4'd0); step("rpost");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
